// File: rtl/sub_bytes_pkg.sv
// Shared types and constants for the byte-serial SubBytes scheduler.
package sub_bytes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

  typedef enum logic {
    OWN_STATE,
    OWN_KEY
  } owner_t;

  localparam int STATE_BYTES = 16;
  localparam int KEY_BYTES   = 4;
  localparam int LEN_W       = 5;

  // Number of operand bytes that pass through the S-boxes for a given owner.
  function automatic logic [LEN_W-1:0] owner_len(input owner_t owner);
    return (owner == OWN_KEY) ? LEN_W'(KEY_BYTES) : LEN_W'(STATE_BYTES);
  endfunction

endpackage

// File: rtl/sub_bytes_sched_if.sv
// Request/response channels between the round datapath, key schedule and the scheduler.
interface sub_bytes_sched_if;

  logic         st_req_valid;
  logic         st_req_ready;
  logic [127:0] st_req_data;
  logic         st_rsp_valid;
  logic         st_rsp_ready;
  logic [127:0] st_rsp_data;

  logic         kw_req_valid;
  logic         kw_req_ready;
  logic [31:0]  kw_req_data;
  logic         kw_rsp_valid;
  logic         kw_rsp_ready;
  logic [31:0]  kw_rsp_data;

  modport master (
    output st_req_valid, st_req_data, st_rsp_ready,
    output kw_req_valid, kw_req_data, kw_rsp_ready,
    input  st_req_ready, st_rsp_valid, st_rsp_data,
    input  kw_req_ready, kw_rsp_valid, kw_rsp_data
  );

  modport slave (
    input  st_req_valid, st_req_data, st_rsp_ready,
    input  kw_req_valid, kw_req_data, kw_rsp_ready,
    output st_req_ready, st_rsp_valid, st_rsp_data,
    output kw_req_ready, kw_rsp_valid, kw_rsp_data
  );

endinterface

// File: rtl/sbox.sv
// AES forward S-box as a combinational 256-entry lookup.
module sbox (
  input  logic [7:0] input_byte,
  output logic [7:0] output_byte
);

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign output_byte = SBOX_TABLE[input_byte];

endmodule

// File: rtl/sub_bytes_sched.sv
// Shares NUM_SBOX S-boxes between the AES state and key-word requesters, streaming bytes in place.
// Define SUB_BYTES_RR_ARB_EN for round-robin arbitration; otherwise the key word has fixed priority.
module sub_bytes_sched
  import sub_bytes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sub_bytes_sched_if.slave    bus,
  output logic                busy
);

  sched_state_t     state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [127:0]     work_q,  work_d;
  logic [LEN_W-1:0] idx_q,   idx_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic             busy_q,  busy_d;

  logic             kw_gnt, st_gnt;
  logic             kw_hs,  st_hs;
  logic             rsp_hs;
  logic [LEN_W:0]   idx_next;

  logic [7:0]       lane_in  [NUM_SBOX];
  logic [7:0]       lane_out [NUM_SBOX];
  logic [LEN_W-1:0] lane_pos [NUM_SBOX];

  // ---------------- arbitration ----------------
`ifdef SUB_BYTES_RR_ARB_EN
  logic last_key_q, last_key_d;

  always_comb begin
    kw_gnt = 1'b0;
    st_gnt = 1'b0;
    if (bus.kw_req_valid && bus.st_req_valid) begin
      if (last_key_q) st_gnt = 1'b1;
      else            kw_gnt = 1'b1;
    end else begin
      kw_gnt = bus.kw_req_valid;
      st_gnt = bus.st_req_valid;
    end
  end

  // Remembers the most recent winner; only a real handshake moves it.
  always_comb begin
    last_key_d = last_key_q;
    if (kw_hs)      last_key_d = 1'b1;
    else if (st_hs) last_key_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_key_q <= 1'b0;
    else        last_key_q <= last_key_d;
  end
`else
  assign kw_gnt = bus.kw_req_valid;
  assign st_gnt = bus.st_req_valid & ~bus.kw_req_valid;
`endif

  // Ready is combinational from valid, so it is gated with rst_n to read 0 in reset.
  assign bus.kw_req_ready = rst_n & (state_q == IDLE) & kw_gnt;
  assign bus.st_req_ready = rst_n & (state_q == IDLE) & st_gnt;
  assign kw_hs            = bus.kw_req_ready;
  assign st_hs            = bus.st_req_ready;

  // ---------------- S-box lanes ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SBOX; gi++) begin : g_lane
      assign lane_pos[gi] = idx_q + LEN_W'(gi);
      assign lane_in[gi]  = work_q[{lane_pos[gi][3:0], 3'b000} +: 8];
      sbox u_sbox (
        .input_byte  (lane_in[gi]),
        .output_byte (lane_out[gi])
      );
    end
  endgenerate

  assign idx_next = {1'b0, idx_q} + (LEN_W + 1)'(NUM_SBOX);

  // ---------------- response side ----------------
  assign bus.st_rsp_valid = (state_q == DONE) && (owner_q == OWN_STATE);
  assign bus.kw_rsp_valid = (state_q == DONE) && (owner_q == OWN_KEY);
  assign bus.st_rsp_data  = work_q;
  assign bus.kw_rsp_data  = work_q[31:0];
  assign rsp_hs           = (owner_q == OWN_KEY) ? bus.kw_rsp_ready : bus.st_rsp_ready;

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    work_d  = work_q;
    idx_d   = idx_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (kw_hs) begin
          work_d  = {96'h0, bus.kw_req_data};
          owner_d = OWN_KEY;
          len_d   = owner_len(OWN_KEY);
          idx_d   = '0;
          state_d = RUN;
        end else if (st_hs) begin
          work_d  = bus.st_req_data;
          owner_d = OWN_STATE;
          len_d   = owner_len(OWN_STATE);
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Lanes that fall past the operand length leave their byte untouched.
        for (int j = 0; j < NUM_SBOX; j++) begin
          if (lane_pos[j] < len_q) begin
            work_d[{lane_pos[j][3:0], 3'b000} +: 8] = lane_out[j];
          end
        end
        idx_d = idx_next[LEN_W-1:0];
        if (idx_next >= {1'b0, len_q}) state_d = DONE;
      end
      DONE: begin
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);
  assign busy   = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_STATE;
      work_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_sub_bytes_sched.sv
// Directed bench for sub_bytes_sched: scoreboard of expected responses built from an algebraic S-box model.
module tb_sub_bytes_sched;
  import sub_bytes_pkg::*;

  parameter int NUM_SBOX = 4;
  localparam int R_ST = (STATE_BYTES + NUM_SBOX - 1) / NUM_SBOX;
  localparam int R_KW = (KEY_BYTES + NUM_SBOX - 1) / NUM_SBOX;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  sub_bytes_sched_if bus ();

  sub_bytes_sched #(.NUM_SBOX(NUM_SBOX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t         st_q[$];
  exp_t         kw_q[$];
  exp_t         mon_e;
  bit           grant_log[$];
  logic         st_v_prev   = 1'b0;
  logic         kw_v_prev   = 1'b0;
  logic [127:0] last_st_rsp = '0;
  logic [31:0]  last_kw_rsp = '0;

  // ---------------- reference model: GF(2^8) inverse + affine map ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input int nbytes);
    logic [127:0] r;
    r = d;
    for (int i = 0; i < nbytes; i++) r[8*i +: 8] = ref_sbox(d[8*i +: 8]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.kw_req_valid && bus.kw_req_ready) begin
        mon_e.data = ref_sub({96'h0, bus.kw_req_data}, KEY_BYTES);
        mon_e.acc  = cyc;
        kw_q.push_back(mon_e);
        grant_log.push_back(1'b1);
      end
      if (bus.st_req_valid && bus.st_req_ready) begin
        mon_e.data = ref_sub(bus.st_req_data, STATE_BYTES);
        mon_e.acc  = cyc;
        st_q.push_back(mon_e);
        grant_log.push_back(1'b0);
      end
      if (bus.kw_rsp_valid && !kw_v_prev) begin
        check("kw_rsp_expected", 128'(kw_q.size() != 0), 128'd1);
        if (kw_q.size() != 0) check("kw_latency", 128'(cyc - kw_q[0].acc), 128'(R_KW + 1));
      end
      if (bus.st_rsp_valid && !st_v_prev) begin
        check("st_rsp_expected", 128'(st_q.size() != 0), 128'd1);
        if (st_q.size() != 0) check("st_latency", 128'(cyc - st_q[0].acc), 128'(R_ST + 1));
      end
      if (bus.kw_rsp_valid && bus.kw_rsp_ready && kw_q.size() != 0) begin
        mon_e = kw_q.pop_front();
        check("kw_data", 128'(bus.kw_rsp_data), mon_e.data);
        last_kw_rsp = bus.kw_rsp_data;
        $display("[TB] cyc %0d kw rsp %h", cyc, bus.kw_rsp_data);
      end
      if (bus.st_rsp_valid && bus.st_rsp_ready && st_q.size() != 0) begin
        mon_e = st_q.pop_front();
        check("st_data", bus.st_rsp_data, mon_e.data);
        last_st_rsp = bus.st_rsp_data;
        $display("[TB] cyc %0d st rsp %h", cyc, bus.st_rsp_data);
      end
    end
    kw_v_prev = bus.kw_rsp_valid;
    st_v_prev = bus.st_rsp_valid;
  end

  // ---------------- driver helpers ----------------
  task automatic send_st(input logic [127:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.st_req_valid = 1'b1;
    bus.st_req_data  = d;
    do begin @(negedge clk); n++; end while (!bus.st_req_ready && n < 50);
    check("st_accept", 128'(bus.st_req_ready), 128'd1);
    @(posedge clk); #1;
    bus.st_req_valid = 1'b0;
  endtask

  task automatic send_kw(input logic [31:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.kw_req_valid = 1'b1;
    bus.kw_req_data  = d;
    do begin @(negedge clk); n++; end while (!bus.kw_req_ready && n < 50);
    check("kw_accept", 128'(bus.kw_req_ready), 128'd1);
    @(posedge clk); #1;
    bus.kw_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
      while ((busy || st_q.size() != 0 || kw_q.size() != 0) && n < 200);
    check("idle_reached", 128'(n < 200), 128'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_st_req_ready"}, 128'(bus.st_req_ready), 128'd0);
    check({tag, "_kw_req_ready"}, 128'(bus.kw_req_ready), 128'd0);
    check({tag, "_st_rsp_valid"}, 128'(bus.st_rsp_valid), 128'd0);
    check({tag, "_kw_rsp_valid"}, 128'(bus.kw_rsp_valid), 128'd0);
    check({tag, "_st_rsp_data"},  bus.st_rsp_data,        128'd0);
    check({tag, "_kw_rsp_data"},  128'(bus.kw_rsp_data),  128'd0);
    check({tag, "_busy"},         128'(busy),             128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] held;
    int           n;
    bit           exp_key;

    rst_n            = 1'b1;
    bus.st_req_valid = 1'b1;
    bus.st_req_data  = 128'h1;
    bus.kw_req_valid = 1'b1;
    bus.kw_req_data  = 32'h1234;
    bus.st_rsp_ready = 1'b1;
    bus.kw_rsp_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset: outputs forced to zero even with both requests valid.
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("in_reset");
    bus.st_req_valid = 1'b0;
    bus.kw_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("after_reset");

    // All-zero state and known-answer vectors.
    send_st(128'h0);
    wait_idle();
    check("zero_state_kat", last_st_rsp, {16{8'h63}});

    send_st(128'h00112233445566778899AABBCCDDEEFF);
    wait_idle();
    check("state_kat", last_st_rsp, 128'h638293C31BFC33F5C4EEACEA4BC12816);

    send_kw(32'hCF4F3C09);
    wait_idle();
    check("key_kat", 128'(last_kw_rsp), 128'h8A84EB01);

    for (int i = 0; i < 3; i++) begin
      send_st({$urandom, $urandom, $urandom, $urandom});
      wait_idle();
      send_kw($urandom);
      wait_idle();
    end

    // Backpressure on the state response with a key request waiting.
    bus.st_rsp_ready = 1'b0;
    send_st({$urandom, $urandom, $urandom, $urandom});
    @(posedge clk); #1;
    bus.kw_req_valid = 1'b1;
    bus.kw_req_data  = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.st_rsp_valid && n < 50);
    check("bp_rsp_seen", 128'(bus.st_rsp_valid), 128'd1);
    held = bus.st_rsp_data;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid",    128'(bus.st_rsp_valid), 128'd1);
      check("bp_data",     bus.st_rsp_data,        held);
      check("bp_st_ready", 128'(bus.st_req_ready), 128'd0);
      check("bp_kw_ready", 128'(bus.kw_req_ready), 128'd0);
      check("bp_busy",     128'(busy),             128'd1);
    end
    @(posedge clk); #1;
    bus.st_rsp_ready = 1'b1;
    @(negedge clk);
    check("hs_cycle_kw_ready", 128'(bus.kw_req_ready), 128'd0);
    check("hs_cycle_busy",     128'(busy),             128'd1);
    @(negedge clk);
    check("post_hs_kw_ready",  128'(bus.kw_req_ready), 128'd1);
    @(posedge clk); #1;
    bus.kw_req_valid = 1'b0;
    wait_idle();

    // Reset in cycle k+2 of a state request.
    @(posedge clk); #1;
    bus.st_req_valid = 1'b1;
    bus.st_req_data  = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.st_req_ready && n < 50);
    check("rst_run_accept", 128'(bus.st_req_ready), 128'd1);
    @(posedge clk); #1;
    bus.st_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    st_q.delete();
    bus.kw_req_valid = 1'b1;
    #1;
    check_outputs_zero("mid_run_reset");
    repeat (2) @(posedge clk);
    #1;
    bus.kw_req_valid = 1'b0;
    rst_n = 1'b1;
    send_kw($urandom);
    wait_idle();

    // Contention from a fresh reset: both requests valid every cycle.
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_log.delete();
    @(posedge clk); #1;
    bus.st_req_valid = 1'b1;
    bus.kw_req_valid = 1'b1;
    repeat (40) begin
      bus.st_req_data = {$urandom, $urandom, $urandom, $urandom};
      bus.kw_req_data = $urandom;
      @(posedge clk); #1;
    end
    bus.st_req_valid = 1'b0;
    bus.kw_req_valid = 1'b0;
    wait_idle();
    check("cont_grants_enough", 128'(grant_log.size() >= 4), 128'd1);
    for (int i = 0; i < grant_log.size(); i++) begin
`ifdef SUB_BYTES_RR_ARB_EN
      exp_key = (i % 2 == 0);
`else
      exp_key = 1'b1;
`endif
      check("cont_grant", 128'(grant_log[i]), 128'(exp_key));
    end

    check("scoreboard_empty", 128'(st_q.size() + kw_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sub_bytes_sched.md
# sub_bytes_sched

Byte-serial SubBytes scheduler that shares a small pool of `sbox` instances between two requesters. The AES round datapath submits a 128-bit state and the key expansion submits a 32-bit word. The block arbitrates between them, streams the captured operand through `NUM_SBOX` S-boxes over several cycles, and returns the substituted result on a valid/ready response port. It sits between the round controller / key schedule and the S-box instances, and replaces the 20 parallel S-boxes a fully unrolled design would need.

## Interface
- `NUM_SBOX`, default 4: number of `sbox` instances; legal values are 1, 2, 4, 8 and 16.
- `clk`  in  1  rising-edge clock; the block has one clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `st_req_valid` / `st_req_ready`  in / out  1 / 1  state request handshake.
- `st_req_data`  in  128  state operand; byte i is bits [8i+7:8i].
- `st_rsp_valid` / `st_rsp_ready`  out / in  1 / 1  state response handshake.
- `st_rsp_data`  out  128  substituted state.
- `kw_req_valid` / `kw_req_ready`  in / out  1 / 1  key-word request handshake.
- `kw_req_data`  in  32  key word operand, same byte order as the state.
- `kw_rsp_valid` / `kw_rsp_ready`  out / in  1 / 1  key-word response handshake.
- `kw_rsp_data`  out  32  substituted key word.
- `busy`  out  1  high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - The arbiter selects one requester with `valid` high.
  - Only the granted port drives `ready` high, combinationally from the `valid` inputs.
  - On handshake the block captures the operand into the 128-bit work register (a key word goes into bits [31:0]), records the owner, sets `len` to 16 or 4, sets `idx` to 0, and moves to RUN.
- **RUN**
  - Each cycle, bytes `idx` through `idx+NUM_SBOX-1` pass through the S-boxes and are written back in place.
  - Bytes at or beyond `len` are left untouched.
  - `idx` advances by `NUM_SBOX`.
  - When `idx + NUM_SBOX >= len`, the block moves to DONE.
  - Both `req_ready` outputs are low.
- **DONE**
  - The owner's `rsp_valid` is high and its `rsp_data` shows the work register; the other port's `rsp_valid` stays low.
  - The state holds until the owner's `rsp_ready` is high, then moves to IDLE.
  - A new request can be accepted in the cycle after the response handshake, not the same cycle.
- **Arbitration:** key word has fixed priority over state.
- **Data outputs:** `st_rsp_data` / `kw_rsp_data` always mirror work register bits [127:0] / [31:0]. They are meaningful only while the matching `rsp_valid` is high.
- **Reset:** asserting `rst_n` at any point, including mid-RUN, discards the operation and returns the FSM to IDLE.
  - Work register, `idx`, owner and round-robin pointer reset to 0.
  - All outputs read 0 while `rst_n` is low: both `req_ready`, both `rsp_valid`, both `rsp_data` and `busy`.

## Timing
- Accept cycle k is the IDLE cycle with a handshake.
- RUN occupies cycles k+1 through k+r, where r = ceil(len / NUM_SBOX).
- `rsp_valid` rises in cycle k+r+1.
- With `NUM_SBOX` = 4: state has r=4 and response at k+5; key word has r=1 and response at k+2.
- Minimum spacing between requests is r+2 cycles when `rsp_ready` is tied high.
- `busy` is registered and high from cycle k+1 until the response handshake cycle, inclusive.
- A `valid` that drops before a handshake is not a violation; the arbiter simply re-evaluates.

## Configuration
- Macro `SUB_BYTES_RR_ARB_EN`.
- **Defined:** round-robin arbitration.
  - When both requests are valid, the port not granted most recently wins.
  - The pointer resets so that the first contention grants the key word.
  - The pointer updates only on a request handshake.
- **Undefined:** fixed priority, key word over state; the pointer logic is absent.

## Structure
- Package `sub_bytes_pkg` holds:
  - `sched_state_t` enum: IDLE, RUN, DONE.
  - `owner_t` enum: OWN_STATE, OWN_KEY.
  - Constants `STATE_BYTES` = 16 and `KEY_BYTES` = 4.
- The only sub-module is the existing `sbox` (ports `input_byte` / `output_byte`), instantiated `NUM_SBOX` times in a generate loop.
- The byte-lane mux and write-back stay in this module.

## Test plan
- **All-zero state:** state 128'h0, `NUM_SBOX`=4 -> `st_rsp_data` = 128'h6363…63 (all 0x63), `st_rsp_valid` at k+5.
- **Known-answer state:** state 128'h00112233445566778899AABBCCDDEEFF -> 128'h638293C31BFC33F5C4EEACEA4BC12816, repeated for `NUM_SBOX` = 1, 2, 4, 8, 16 with r = 16, 8, 4, 2, 1.
- **Key word:** key word 32'hCF4F3C09 -> `kw_rsp_data` = 32'h8A84EB01 at k+2; `st_rsp_valid` stays 0 throughout.
- **Contention:**
  - Both valid every cycle with `rsp_ready` high, macro undefined -> key granted every time.
  - Same stimulus, macro defined -> grants alternate key, state, key, …
- **Backpressure:** `st_rsp_ready` held 0 for 10 cycles -> `rsp_valid` and data stable, both `req_ready` 0, `busy` 1; a new request is accepted the cycle after the handshake.
- **Reset mid-RUN:** `rst_n` low in cycle k+2 of a state request -> all outputs 0 immediately; after release, a fresh key request completes correctly with no stale response.
